eth_pkt_wr_arbiter: RTL and testbench
=====================================

Name: eth_pkt_wr_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the write port of the Ethernet packet FIFO between up to 4 packet sources.
- Grants one source at a time and forwards its beats until the source's last beat, so packets never interleave in the FIFO.
- Tags each FIFO word with source ID and last flag. Truncates packets longer than MAX_BEATS.
- Sits on the write-clock side, directly in front of the FIFO wr_data/wr_en/wr_vld port.

Parameters:
- N_SRC, 2, number of sources (legal 2..4).
- DW, 32, payload data width per beat.
- MAX_BEATS, 1024, maximum beats per packet before truncation (legal 2..65535).
- FW, DW+3, FIFO word width = {last, src_id[1:0], data}. Fixed derivation, not overridable.

Ports:
- wr_clk, in, 1, single clock for the block.
- wr_rst, in, 1, reset, synchronous, active-high.
- enable, in, 1, 1 = new grants allowed; a packet already in flight always completes.
- src_data, in, N_SRC*DW, flat source payload bus, source i at [i*DW +: DW].
- src_valid, in, N_SRC, per-source beat valid.
- src_last, in, N_SRC, per-source last-beat flag, qualified by src_valid.
- src_ready, out, N_SRC, per-source beat accept.
- fifo_wr_data, out, FW, {last, src_id, data} to the FIFO write data.
- fifo_wr_en, out, 1, FIFO write strobe.
- fifo_wr_vld, in, 1, FIFO not-full.
- busy, out, 1, state is not IDLE.
- pkt_cnt, out, 16, packets written, wraps at 65535 -> 0.
- trunc_cnt, out, 8, truncated packets, saturates at 255.

Behaviour:
- Reset (synchronous, any state): state=IDLE, last_grant=N_SRC-1 (so source 0 wins first), beat_cnt=0, pkt_cnt=0, trunc_cnt=0. All outputs are 0: src_ready, fifo_wr_en, busy, fifo_wr_data. A packet in flight is abandoned and no further beats are written.
- State IDLE:
  - If enable=1 and any src_valid, grant the first valid source searching last_grant+1, last_grant+2, ... modulo N_SRC.
  - Register grant, set last_grant=grant, beat_cnt=0, go to BURST. Arbitration costs exactly 1 cycle.
  - No src_ready is asserted in IDLE.
- State BURST (owner g):
  - src_ready[g] = fifo_wr_vld (combinational); all other ready bits are 0.
  - fifo_wr_en = src_valid[g] & fifo_wr_vld.
  - fifo_wr_data = {last_out, g[1:0], src_data[g]}.
  - A beat is accepted when fifo_wr_en=1; beat_cnt increments on each accepted beat.
  - last_out = src_last[g] | (beat_cnt==MAX_BEATS-1).
  - Accepted beat with src_last[g]=1: pkt_cnt++, go to IDLE.
  - Accepted beat with beat_cnt==MAX_BEATS-1 and src_last[g]=0: write it with last=1, pkt_cnt++, trunc_cnt++ (saturating), go to DROP.
  - fifo_wr_vld=0 stalls with no write and no accept; hold state.
- State DROP (owner g):
  - src_ready[g]=1 and fifo_wr_en=0; discard beats.
  - Go to IDLE on src_valid[g] & src_last[g].
- Minimum one IDLE cycle between packets. Back-to-back single-beat packets from one source alone therefore give 1 write per 2 cycles.
- enable falling mid-BURST has no effect until the packet ends; IDLE then holds with no grants.
- Source valid dropping mid-packet is a bubble; grant is held.
- MAX_BEATS=N means at most N beats per written packet.
- busy = (state != IDLE), registered.
- When N_SRC<4, src_id uses the low bits, and unused src_id values never appear on fifo_wr_data.

Test Plan:
- Single source: src0 sends 4 beats D0..D3, last on D3, fifo_wr_vld=1 -> grant 1 cycle after valid; 4 consecutive fifo_wr_en with fifo_wr_data[FW-1:FW-3] = 0,00 / 0,00 / 0,00 / 1,00; pkt_cnt=1; busy back to 0.
- Round robin: sources 0 and 1 both continuously offer 2-beat packets -> packet order 0,1,0,1; no beat interleaving; each packet end followed by exactly one idle cycle.
- Backpressure: fifo_wr_vld=0 for 3 cycles mid-packet -> src_ready[g]=0 and fifo_wr_en=0 in those cycles; no lost or duplicated beat; data order preserved.
- Truncation: MAX_BEATS=4, src1 sends 7 beats -> 4 writes, 4th carries last=1; 3 remaining beats are accepted with no write; pkt_cnt=1, trunc_cnt=1; next grant goes to src0 if src0 is valid.
- Enable gating: enable=0 during a packet -> packet completes; src2 then valid -> no grant until enable=1, granted 1 cycle after that.
- Reset mid-packet: assert wr_rst for 1 cycle after beat 2 of 5 -> next cycle state IDLE, counters 0, no writes; after release the first grant goes to source 0 when sources 0 and 1 are both valid.

Source files
------------

// File: rtl/eth_pkt_wr_arbiter.sv
// Packet-atomic round-robin arbiter for the Ethernet packet FIFO write port.
// One source owns the FIFO from grant until its last beat, so packets never interleave.
// Each FIFO word is tagged {last, src_id, data}; over-long packets are cut at MAX_BEATS
// and the remainder of the source packet is drained without writing.
module eth_pkt_wr_arbiter #(
   parameter int unsigned N_SRC     = 2,
   parameter int unsigned DW        = 32,
   parameter int unsigned MAX_BEATS = 1024
) (
   input  logic                wr_clk,
   input  logic                wr_rst,
   input  logic                enable,
   input  logic [N_SRC*DW-1:0] src_data,
   input  logic [N_SRC-1:0]    src_valid,
   input  logic [N_SRC-1:0]    src_last,
   output logic [N_SRC-1:0]    src_ready,
   output logic [DW+2:0]       fifo_wr_data,
   output logic                fifo_wr_en,
   input  logic                fifo_wr_vld,
   output logic                busy,
   output logic [15:0]         pkt_cnt,
   output logic [7:0]          trunc_cnt
);

   localparam int unsigned FW          = DW + 3;
   localparam logic [15:0] LastBeatIdx = 16'(MAX_BEATS - 1);
   localparam logic [1:0]  LastSrc     = 2'(N_SRC - 1);

   typedef enum logic [1:0] {StIdle, StBurst, StDrop} state_e;

   state_e        state;
   logic [1:0]    grant;
   logic [1:0]    last_grant;
   logic [15:0]   beat_cnt;

   // Sources widened to 4 so a 2-bit grant can index without range issues.
   logic [3:0]    valid_pad;
   logic [3:0]    last_pad;
   logic [DW-1:0] data_arr [4];

   logic [1:0]    cand;
   logic [1:0]    arb_idx;
   logic          arb_hit;
   logic          at_max;
   logic          last_out;
   logic          ready_any;
   logic [FW-1:0] wr_word;

   assign valid_pad = 4'(src_valid);
   assign last_pad  = 4'(src_last);

   for (genvar gi = 0; gi < 4; gi++) begin : g_pad
      if (gi < N_SRC) begin : g_used
         assign data_arr[gi] = src_data[gi*DW +: DW];
      end else begin : g_unused
         assign data_arr[gi] = '0;
      end
   end

   // Round-robin pick: first valid source after last_grant, wrapping modulo N_SRC.
   always_comb begin
      cand    = '0;
      arb_hit = 1'b0;
      arb_idx = LastSrc;
      for (int unsigned k = 1; k <= N_SRC; k++) begin
         cand = 2'((32'(last_grant) + k) % N_SRC);
         if (!arb_hit && valid_pad[cand]) begin
            arb_hit = 1'b1;
            arb_idx = cand;
         end
      end
   end

   assign at_max   = (beat_cnt == LastBeatIdx);
   assign last_out = last_pad[grant] | at_max;

   // Handshake and FIFO write path; forced quiet while reset is asserted so an
   // abandoned packet cannot leak a beat in the reset cycle.
   always_comb begin
      ready_any  = 1'b0;
      fifo_wr_en = 1'b0;
      wr_word    = '0;
      src_ready  = '0;
      if (!wr_rst) begin
         case (state)
            StBurst: begin
               ready_any  = fifo_wr_vld;
               fifo_wr_en = valid_pad[grant] & fifo_wr_vld;
               wr_word    = {last_out, grant, data_arr[grant]};
            end
            StDrop: begin
               ready_any = 1'b1;
            end
            default: begin
               ready_any = 1'b0;
            end
         endcase
      end
      for (int unsigned i = 0; i < N_SRC; i++) begin
         src_ready[i] = (32'(grant) == i) & ready_any;
      end
   end

   assign fifo_wr_data = wr_word;

   // Arbitration FSM with beat/packet/truncation counters and registered busy.
   always_ff @(posedge wr_clk) begin
      if (wr_rst) begin
         state      <= StIdle;
         grant      <= '0;
         last_grant <= LastSrc;
         beat_cnt   <= '0;
         pkt_cnt    <= '0;
         trunc_cnt  <= '0;
         busy       <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (enable && arb_hit) begin
                  grant      <= arb_idx;
                  last_grant <= arb_idx;
                  beat_cnt   <= '0;
                  state      <= StBurst;
                  busy       <= 1'b1;
               end
            end
            StBurst: begin
               if (fifo_wr_en) begin
                  beat_cnt <= beat_cnt + 16'd1;
                  if (last_pad[grant]) begin
                     pkt_cnt <= pkt_cnt + 16'd1;
                     state   <= StIdle;
                     busy    <= 1'b0;
                  end else if (at_max) begin
                     // Packet cut short: the written copy is closed here, rest is drained.
                     pkt_cnt <= pkt_cnt + 16'd1;
                     if (trunc_cnt != 8'hFF) begin
                        trunc_cnt <= trunc_cnt + 8'd1;
                     end
                     state <= StDrop;
                  end
               end
            end
            StDrop: begin
               if (valid_pad[grant] && last_pad[grant]) begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_eth_pkt_wr_arbiter.sv
// Self-checking bench for eth_pkt_wr_arbiter: directed scenarios plus a randomized
// phase scored against per-source expected FIFO word streams.
module tb_eth_pkt_wr_arbiter;

   localparam int unsigned N_SRC     = 3;
   localparam int unsigned DW        = 16;
   localparam int unsigned MAX_BEATS = 4;
   localparam int unsigned FW        = DW + 3;

   logic                wr_clk = 1'b0;
   logic                wr_rst;
   logic                enable;
   logic [N_SRC*DW-1:0] src_data;
   logic [N_SRC-1:0]    src_valid;
   logic [N_SRC-1:0]    src_last;
   logic [N_SRC-1:0]    src_ready;
   logic [FW-1:0]       fifo_wr_data;
   logic                fifo_wr_en;
   logic                fifo_wr_vld;
   logic                busy;
   logic [15:0]         pkt_cnt;
   logic [7:0]          trunc_cnt;

   always #5 wr_clk = ~wr_clk;

   eth_pkt_wr_arbiter #(
      .N_SRC     (N_SRC),
      .DW        (DW),
      .MAX_BEATS (MAX_BEATS)
   ) dut (
      .wr_clk       (wr_clk),
      .wr_rst       (wr_rst),
      .enable       (enable),
      .src_data     (src_data),
      .src_valid    (src_valid),
      .src_last     (src_last),
      .src_ready    (src_ready),
      .fifo_wr_data (fifo_wr_data),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_vld  (fifo_wr_vld),
      .busy         (busy),
      .pkt_cnt      (pkt_cnt),
      .trunc_cnt    (trunc_cnt)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Source packet queues: each entry is {last, data}.
   logic [DW:0]      srcq [N_SRC][$];
   logic [FW-1:0]    exp_w [N_SRC][$];
   bit               vld_q [$];
   int unsigned      vprob = 100;
   int unsigned      fprob = 100;

   // Per-cycle trace of the most recent run() and the words it wrote.
   logic             tr_en   [$];
   logic [FW-1:0]    tr_data [$];
   logic [N_SRC-1:0] tr_rdy  [$];
   logic             tr_busy [$];
   logic [FW-1:0]    wq      [$];
   logic [FW-1:0]    all_w   [$];

   int               exp_pkt   = 0;
   int               exp_trunc = 0;

   function automatic logic [DW-1:0] pl(input int s, input int p, input int b);
      return DW'((s << 8) | (p << 4) | b);
   endfunction

   function automatic logic [FW-1:0] word(input bit last, input int s, input logic [DW-1:0] d);
      return {last, 2'(s), d};
   endfunction

   task automatic load(input int s, input int p, input int len);
      for (int b = 0; b < len; b++) srcq[s].push_back({(b == len - 1), pl(s, p, b)});
   endtask

   function automatic bit q_empty();
      for (int i = 0; i < N_SRC; i++) if (srcq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Each cycle: drive at negedge, sample 1 ns later, retire beats the DUT accepted.
   task automatic run(input int ncyc);
      logic [DW:0] b;
      tr_en.delete(); tr_data.delete(); tr_rdy.delete(); tr_busy.delete(); wq.delete();
      for (int c = 0; c < ncyc; c++) begin
         for (int i = 0; i < N_SRC; i++) begin
            if (srcq[i].size() > 0 && $urandom_range(99) < vprob) begin
               b = srcq[i][0];
               src_valid[i]          = 1'b1;
               src_data[i*DW +: DW]  = b[DW-1:0];
               src_last[i]           = b[DW];
            end else begin
               src_valid[i]          = 1'b0;
               src_data[i*DW +: DW]  = DW'($urandom);
               src_last[i]           = 1'($urandom);
            end
         end
         fifo_wr_vld = (vld_q.size() > 0) ? vld_q.pop_front() : ($urandom_range(99) < fprob);
         #1;
         tr_en.push_back(fifo_wr_en);
         tr_data.push_back(fifo_wr_data);
         tr_rdy.push_back(src_ready);
         tr_busy.push_back(busy);
         if (fifo_wr_en) wq.push_back(fifo_wr_data);
         for (int i = 0; i < N_SRC; i++) begin
            if (src_valid[i] && src_ready[i]) void'(srcq[i].pop_front());
         end
         @(negedge wr_clk);
      end
   endtask

   initial begin
      logic [FW-1:0] w;
      logic [1:0]    id;
      logic [1:0]    owner;
      bit            in_pkt;
      int            n, len;
      logic [DW-1:0] d;

      wr_rst = 1'b1; enable = 1'b0; src_valid = '0; src_last = '0; src_data = '0;
      fifo_wr_vld = 1'b1;
      repeat (2) @(negedge wr_clk);

      // Reset state, with sources requesting to show nothing is granted.
      src_valid = '1;
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_pkt_cnt", 32'(pkt_cnt), 0);
      check("rst_trunc_cnt", 32'(trunc_cnt), 0);
      check("rst_wr_en", 32'(fifo_wr_en), 0);
      check("rst_ready", 32'(src_ready), 0);
      check("rst_wr_data", 32'(fifo_wr_data), 0);
      @(negedge wr_clk);
      wr_rst = 1'b0; enable = 1'b1; src_valid = '0;

      // Round robin: sources 0 and 1 each hold two 2-beat packets.
      load(0, 0, 2); load(0, 1, 2); load(1, 0, 2); load(1, 1, 2);
      run(12);
      for (int k = 0; k < 12; k++) begin
         check("rr_wr_en", 32'(tr_en[k]), 32'(k % 3 != 0));
         if (k % 3 != 0) begin
            n = k / 3;
            check("rr_word", 32'(tr_data[k]),
                  32'(word(k % 3 == 2, n % 2, pl(n % 2, n / 2, k % 3 - 1))));
         end
      end
      exp_pkt += 4;

      // Single source, 4 beats, last on the 4th (one short of truncation).
      load(0, 2, 4);
      run(6);
      check("single_c0_en", 32'(tr_en[0]), 0);
      check("single_c0_ready", 32'(tr_rdy[0]), 0);
      check("single_c1_busy", 32'(tr_busy[1]), 1);
      for (int k = 1; k <= 4; k++) begin
         check("single_en", 32'(tr_en[k]), 1);
         check("single_word", 32'(tr_data[k]), 32'(word(k == 4, 0, pl(0, 2, k - 1))));
      end
      check("single_c5_en", 32'(tr_en[5]), 0);
      check("single_c5_busy", 32'(tr_busy[5]), 0);
      exp_pkt += 1;
      check("single_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));

      // Backpressure: fifo_wr_vld low for 3 cycles after two beats.
      load(0, 3, 4);
      vld_q = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
      run(9);
      for (int k = 3; k <= 5; k++) begin
         check("bp_stall_en", 32'(tr_en[k]), 0);
         check("bp_stall_ready", 32'(tr_rdy[k][0]), 0);
      end
      check("bp_nwrites", 32'(wq.size()), 4);
      for (int k = 0; k < 4 && k < wq.size(); k++)
         check("bp_word", 32'(wq[k]), 32'(word(k == 3, 0, pl(0, 3, k))));
      exp_pkt += 1;

      // Truncation: src1 sends 7 beats, src0 waits with a 1-beat packet.
      load(1, 0, 7); load(0, 4, 1);
      run(12);
      check("tr_nwrites", 32'(wq.size()), 5);
      for (int k = 0; k < 4 && k < wq.size(); k++)
         check("tr_word", 32'(wq[k]), 32'(word(k == 3, 1, pl(1, 0, k))));
      for (int k = 5; k <= 7; k++) begin
         check("tr_drop_en", 32'(tr_en[k]), 0);
         check("tr_drop_ready", 32'(tr_rdy[k][1]), 1);
      end
      if (wq.size() > 4) check("tr_next_src0", 32'(wq[4]), 32'(word(1, 0, pl(0, 4, 0))));
      check("tr_src1_drained", 32'(srcq[1].size()), 0);
      exp_pkt += 2; exp_trunc += 1;
      check("tr_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
      check("tr_trunc_cnt", 32'(trunc_cnt), 32'(exp_trunc));

      // Enable gating: drop enable mid-packet, then hold src2 off until re-enabled.
      load(0, 5, 3);
      run(2);
      enable = 1'b0;
      run(4);
      check("en_finish_nwrites", 32'(wq.size()), 2);
      if (wq.size() > 1) check("en_finish_last", 32'(wq[1]), 32'(word(1, 0, pl(0, 5, 2))));
      load(2, 0, 1);
      run(4);
      check("en_held_nwrites", 32'(wq.size()), 0);
      check("en_held_busy", 32'(tr_busy[3]), 0);
      enable = 1'b1;
      run(3);
      check("en_c0_en", 32'(tr_en[0]), 0);
      check("en_c1_word", 32'(tr_en[1] ? tr_data[1] : '0), 32'(word(1, 2, pl(2, 0, 0))));
      exp_pkt += 2;

      // Reset after 2 beats of a 5-beat packet.
      load(0, 6, 5);
      run(3);
      check("rstmid_pre_writes", 32'(wq.size()), 2);
      wr_rst = 1'b1;
      run(1);
      check("rstmid_rst_en", 32'(tr_en[0]), 0);
      for (int i = 0; i < N_SRC; i++) srcq[i].delete();
      wr_rst = 1'b0;
      exp_pkt = 0; exp_trunc = 0;
      check("rstmid_busy", 32'(busy), 0);
      check("rstmid_pkt_cnt", 32'(pkt_cnt), 0);
      check("rstmid_trunc_cnt", 32'(trunc_cnt), 0);
      run(1);
      check("rstmid_no_write", 32'(tr_en[0]), 0);
      load(0, 7, 1); load(1, 7, 1);
      run(6);
      check("rstmid_nwrites", 32'(wq.size()), 2);
      if (wq.size() > 0) check("rstmid_first_src0", 32'(wq[0]), 32'(word(1, 0, pl(0, 7, 0))));
      exp_pkt += 2;

      // Randomized traffic: 8 packets per source, random valid and FIFO-full gaps.
      vprob = 70; fprob = 75;
      for (int i = 0; i < N_SRC; i++) begin
         for (int p = 0; p < 8; p++) begin
            len = int'($urandom_range(1, 7));
            for (int b = 0; b < len; b++) begin
               d = DW'($urandom);
               srcq[i].push_back({(b == len - 1), d});
               if (b < MAX_BEATS)
                  exp_w[i].push_back(word((b == len - 1) || (b == MAX_BEATS - 1), i, d));
            end
            exp_pkt++;
            if (len > MAX_BEATS) exp_trunc++;
         end
      end
      all_w.delete();
      for (int r = 0; r < 40 && !q_empty(); r++) begin
         run(50);
         foreach (wq[k]) all_w.push_back(wq[k]);
      end
      run(4);
      foreach (wq[k]) all_w.push_back(wq[k]);
      check("rand_drained", 32'(q_empty()), 1);

      in_pkt = 1'b0; owner = '0;
      foreach (all_w[k]) begin
         w  = all_w[k];
         id = w[DW+1:DW];
         check("rand_id_range", 32'(id < N_SRC), 1);
         if (in_pkt) check("rand_no_interleave", 32'(id), 32'(owner));
         if (id < N_SRC) begin
            if (exp_w[id].size() > 0) check("rand_word", 32'(w), 32'(exp_w[id].pop_front()));
            else check("rand_extra_beat", 32'(exp_w[id].size()), 1);
         end
         in_pkt = !w[FW-1];
         owner  = id;
      end
      for (int i = 0; i < N_SRC; i++) check("rand_missing", 32'(exp_w[i].size()), 0);
      check("rand_pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
      check("rand_trunc_cnt", 32'(trunc_cnt), 32'(exp_trunc));
      check("rand_idle", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
